usb2_buf_in_arbiter: RTL and testbench

- Shares the single external endpoint IN-buffer port of the USB 2.0 core (buf_in_* on ext_clk) between two independent packet producers, A and B.
- Grants the port to one producer at a time, round-robin, and registers that producer's writes onto the buffer port.
- Runs the commit / commit_ack handshake for the granted producer and releases the grant on completion, timeout or abort.
- Sits between user logic and the core's ext_buf_in interface, entirely in the ext_clk domain.

---
 rtl/usb2_buf_pkg.sv | 37 +++
 rtl/usb2_rr_arb2.sv | 41 ++++
 rtl/usb2_buf_in_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_usb2_buf_in_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb2_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb2_buf_pkg
//  Purpose  : Shared widths, controller state encoding and length helper for
//             the USB 2.0 external IN-buffer port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package usb2_buf_pkg;

    // Buffer port widths of the core's ext_buf_in interface
    localparam int c_addr_w          = 9;
    localparam int c_data_w          = 8;
    localparam int c_len_w           = 10;

    // Largest packet the IN buffer can commit
    localparam int c_max_len_default = 512;

    // Controller state encoding
    typedef logic [2:0] state_t;

    localparam state_t c_st_idle     = 3'd0;
    localparam state_t c_st_grant    = 3'd1;
    localparam state_t c_st_commit   = 3'd2;
    localparam state_t c_st_wait_ack = 3'd3;
    localparam state_t c_st_ack_low  = 3'd4;
    localparam state_t c_st_release  = 3'd5;

    // A commit length is legal when it is non-zero and does not exceed max_len
    function automatic logic len_in_range(input logic [c_len_w-1:0] len,
                                          input int                 max_len);
        logic [31:0] len32;
        len32 = 32'(len);
        return (len32 != 32'd0) && (len32 <= 32'(max_len));
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb2_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : usb2_rr_arb2
//  Purpose  : Two-way round-robin pick. The pointer names the producer that
//             wins a tie; it moves to the other producer whenever the owner
//             of the port is released.
//  Revision : 1.0 - initial release
// ============================================================================
module usb2_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,       // bit 0 = producer A, bit 1 = producer B
    input  logic       update,    // pulse: the current owner is being released
    input  logic       served_b,  // owner being released was B
    output logic       pick_b,    // winner of the current request set is B
    output logic       any_req
);

    logic r_favour_b;

    // Tie-breaker pointer: after a release, favour the producer not just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_favour_b <= 1'b0;
        end else if (update) begin
            r_favour_b <= ~served_b;
        end
    end

    // Single requester wins outright; a tie goes to the favoured producer
    always_comb begin
        any_req = |req;
        if (req == 2'b11) begin
            pick_b = r_favour_b;
        end else begin
            pick_b = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb2_buf_in_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : usb2_buf_in_arbiter
//  Purpose  : Shares the core's single external IN-buffer port between two
//             packet producers A and B. One producer owns the port at a time
//             (round-robin); its writes are registered onto buf_in_*, and its
//             commit is carried through the 4-phase commit/commit_ack
//             handshake with an acknowledge timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module usb2_buf_in_arbiter
    import usb2_buf_pkg::*;
#(
    parameter int MAX_LEN     = c_max_len_default,
    parameter int ACK_TIMEOUT = 65535,
    parameter int CNT_W       = 16     // 2**CNT_W must exceed ACK_TIMEOUT
) (
    input  logic                ext_clk,
    input  logic                reset_n,

    input  logic                a_req,
    output logic                a_gnt,
    input  logic [c_addr_w-1:0] a_addr,
    input  logic [c_data_w-1:0] a_data,
    input  logic                a_wren,
    input  logic                a_commit,
    input  logic [c_len_w-1:0]  a_commit_len,
    output logic                a_done,
    output logic                a_err,

    input  logic                b_req,
    output logic                b_gnt,
    input  logic [c_addr_w-1:0] b_addr,
    input  logic [c_data_w-1:0] b_data,
    input  logic                b_wren,
    input  logic                b_commit,
    input  logic [c_len_w-1:0]  b_commit_len,
    output logic                b_done,
    output logic                b_err,

    output logic [c_addr_w-1:0] buf_in_addr,
    output logic [c_data_w-1:0] buf_in_data,
    output logic                buf_in_wren,
    input  logic                buf_in_ready,
    output logic                buf_in_commit,
    output logic [c_len_w-1:0]  buf_in_commit_len,
    input  logic                buf_in_commit_ack,

    output logic [1:0]          stat_owner
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(ACK_TIMEOUT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic                  r_owner_b;
    logic                  r_a_gnt;
    logic                  r_b_gnt;
    logic [c_addr_w-1:0]   r_addr;
    logic [c_data_w-1:0]   r_data;
    logic                  r_wren;
    logic                  r_commit;
    logic [c_len_w-1:0]    r_len;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_a_done;
    logic                  r_a_err;
    logic                  r_b_done;
    logic                  r_b_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                w_next;
    logic                  w_pick_b;
    logic                  w_any_req;
    logic                  w_release;
    logic                  w_own_req;
    logic                  w_own_wren;
    logic                  w_own_commit;
    logic [c_addr_w-1:0]   w_own_addr;
    logic [c_data_w-1:0]   w_own_data;
    logic [c_len_w-1:0]    w_own_len;
    logic                  w_len_ok;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_timeout;
    logic                  w_reject;
    logic                  w_expire;
    logic                  w_ack_done;

    // ------------------------------------------------------------------
    // Round-robin pick; the pointer advances once per release
    // ------------------------------------------------------------------
    assign w_release = (r_state == c_st_release);

    usb2_rr_arb2 u_rr_arb2 (
        .clk      (ext_clk),
        .rst_n    (reset_n),
        .req      ({b_req, a_req}),
        .update   (w_release),
        .served_b (r_owner_b),
        .pick_b   (w_pick_b),
        .any_req  (w_any_req)
    );

    // Route the owning producer's controls; the other producer is never seen
    always_comb begin
        if (r_owner_b) begin
            w_own_req    = b_req;
            w_own_wren   = b_wren;
            w_own_commit = b_commit;
            w_own_addr   = b_addr;
            w_own_data   = b_data;
            w_own_len    = b_commit_len;
        end else begin
            w_own_req    = a_req;
            w_own_wren   = a_wren;
            w_own_commit = a_commit;
            w_own_addr   = a_addr;
            w_own_data   = a_data;
            w_own_len    = a_commit_len;
        end
    end

    assign w_len_ok = len_in_range(w_own_len, MAX_LEN);

    // Saturating increment: the counter may stick at all-ones but never wraps
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout  = (w_cnt_inc >= c_timeout);

    // Completion events; an acknowledge outranks a simultaneous timeout
    assign w_reject   = (r_state == c_st_grant) && w_own_commit && !w_len_ok;
    assign w_ack_done = (r_state == c_st_wait_ack) && buf_in_commit_ack;
    assign w_expire   = (r_state == c_st_wait_ack) && !buf_in_commit_ack && w_timeout;

    // Next-state selection for the ownership / commit sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (buf_in_ready && w_any_req) begin
                    w_next = c_st_grant;
                end
            end
            c_st_grant: begin
                if (w_own_commit) begin
                    w_next = w_len_ok ? c_st_commit : c_st_release;
                end else if (!w_own_req) begin
                    w_next = c_st_release;
                end
            end
            c_st_commit: begin
                w_next = c_st_wait_ack;
            end
            c_st_wait_ack: begin
                if (buf_in_commit_ack) begin
                    w_next = c_st_ack_low;
                end else if (w_timeout) begin
                    w_next = c_st_release;
                end
            end
            c_st_ack_low: begin
                if (!buf_in_commit_ack) begin
                    w_next = c_st_release;
                end
            end
            c_st_release: begin
                w_next = c_st_idle;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    // State register
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Ownership and grants: set when leaving IDLE, cleared on any release path
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner_b <= 1'b0;
            r_a_gnt   <= 1'b0;
            r_b_gnt   <= 1'b0;
        end else if ((r_state == c_st_idle) && (w_next == c_st_grant)) begin
            r_owner_b <= w_pick_b;
            r_a_gnt   <= ~w_pick_b;
            r_b_gnt   <= w_pick_b;
        end else if (w_next == c_st_release) begin
            r_a_gnt   <= 1'b0;
            r_b_gnt   <= 1'b0;
        end
    end

    // Write path: only the owner's writes while in GRANT reach the core
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_wren <= 1'b0;
        end else begin
            r_wren <= (r_state == c_st_grant) && w_own_wren;
            if ((r_state == c_st_grant) && w_own_wren) begin
                r_addr <= w_own_addr;
                r_data <= w_own_data;
            end
        end
    end

    // Accepted length is latched in GRANT and held through the handshake
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len <= '0;
        end else if ((r_state == c_st_grant) && w_own_commit && w_len_ok) begin
            r_len <= w_own_len;
        end
    end

    // Commit level and acknowledge timeout; the counter restarts on each entry
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_commit <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == c_st_commit) begin
            r_commit <= 1'b1;
            r_cnt    <= '0;
        end else if (r_state == c_st_wait_ack) begin
            if (buf_in_commit_ack || w_timeout) begin
                r_commit <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_inc;
            end
        end
    end

    // One-cycle done/err pulses, steered to the owning producer only
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_done <= 1'b0;
            r_a_err  <= 1'b0;
            r_b_done <= 1'b0;
            r_b_err  <= 1'b0;
        end else begin
            r_a_done <= w_ack_done && !r_owner_b;
            r_b_done <= w_ack_done &&  r_owner_b;
            r_a_err  <= (w_reject || w_expire) && !r_owner_b;
            r_b_err  <= (w_reject || w_expire) &&  r_owner_b;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_gnt             = r_a_gnt;
    assign b_gnt             = r_b_gnt;
    assign a_done            = r_a_done;
    assign a_err             = r_a_err;
    assign b_done            = r_b_done;
    assign b_err             = r_b_err;
    assign buf_in_addr       = r_addr;
    assign buf_in_data       = r_data;
    assign buf_in_wren       = r_wren;
    assign buf_in_commit     = r_commit;
    assign buf_in_commit_len = r_len;
    assign stat_owner        = {r_b_gnt, r_a_gnt};

endmodule
`default_nettype wire

// File: tb/tb_usb2_buf_in_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb2_buf_in_arbiter
//  Purpose  : Self-checking bench for usb2_buf_in_arbiter: a cycle model of
//             the ownership/commit rules compared every cycle, plus directed
//             scenarios with hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb2_buf_in_arbiter;

    localparam int TO  = 100;
    localparam int MAX = 512;

    logic       ext_clk = 1'b0;
    logic       reset_n;
    logic       a_req, a_wren, a_commit, b_req, b_wren, b_commit;
    logic [8:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic [9:0] a_commit_len, b_commit_len;
    logic       buf_in_ready, buf_in_commit_ack;
    logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren, buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic [1:0] stat_owner;

    always #5 ext_clk = ~ext_clk;

    usb2_buf_in_arbiter #(.MAX_LEN(MAX), .ACK_TIMEOUT(TO), .CNT_W(16)) dut (
        .ext_clk(ext_clk), .reset_n(reset_n),
        .a_req(a_req), .a_gnt(a_gnt), .a_addr(a_addr), .a_data(a_data),
        .a_wren(a_wren), .a_commit(a_commit), .a_commit_len(a_commit_len),
        .a_done(a_done), .a_err(a_err),
        .b_req(b_req), .b_gnt(b_gnt), .b_addr(b_addr), .b_data(b_data),
        .b_wren(b_wren), .b_commit(b_commit), .b_commit_len(b_commit_len),
        .b_done(b_done), .b_err(b_err),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
        .buf_in_wren(buf_in_wren), .buf_in_ready(buf_in_ready),
        .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
        .buf_in_commit_ack(buf_in_commit_ack), .stat_owner(stat_owner)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string what);
        total++;
        bad++;
        $display("FAIL %s: got no event, required one within the cycle budget", what);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the port and which phase of its packet
    // ------------------------------------------------------------------
    localparam int P_FREE = 0, P_WRITING = 1, P_SETTLE = 2, P_AWAIT = 3,
                   P_DRAIN = 4, P_LEAVING = 5;
    int         m_phase, m_owner, m_wait;   // owner: 0 none, 1 A, 2 B
    bit         m_favour_b;
    logic [9:0] m_len;
    logic [8:0] e_addr;
    logic [7:0] e_data;
    logic       e_wren, e_a_done, e_a_err, e_b_done, e_b_err;

    task automatic model_reset();
        m_phase = P_FREE; m_owner = 0; m_wait = 0; m_favour_b = 1'b0;
        m_len = '0; e_addr = '0; e_data = '0; e_wren = 1'b0;
        e_a_done = 1'b0; e_a_err = 1'b0; e_b_done = 1'b0; e_b_err = 1'b0;
    endtask

    task automatic owner_pulse(input bit is_err);
        if (m_owner == 1) begin
            if (is_err) e_a_err = 1'b1; else e_a_done = 1'b1;
        end else begin
            if (is_err) e_b_err = 1'b1; else e_b_done = 1'b1;
        end
    endtask

    task automatic model_step();
        logic       o_req, o_wren, o_commit;
        logic [8:0] o_addr;
        logic [7:0] o_data;
        logic [9:0] o_len;
        e_a_done = 1'b0; e_a_err = 1'b0; e_b_done = 1'b0; e_b_err = 1'b0;
        e_wren = 1'b0;
        if (m_owner == 2) begin
            o_req = b_req; o_wren = b_wren; o_commit = b_commit;
            o_addr = b_addr; o_data = b_data; o_len = b_commit_len;
        end else begin
            o_req = a_req; o_wren = a_wren; o_commit = a_commit;
            o_addr = a_addr; o_data = a_data; o_len = a_commit_len;
        end
        case (m_phase)
            P_FREE: if (buf_in_ready && (a_req || b_req)) begin
                if (a_req && b_req) m_owner = m_favour_b ? 2 : 1;
                else                m_owner = a_req ? 1 : 2;
                m_phase = P_WRITING;
            end
            P_WRITING: begin
                e_wren = o_wren;
                if (o_wren) begin e_addr = o_addr; e_data = o_data; end
                if (o_commit) begin
                    if (o_len >= 1 && o_len <= MAX) begin
                        m_len = o_len; m_phase = P_SETTLE;
                    end else begin
                        owner_pulse(1'b1); m_phase = P_LEAVING;
                    end
                end else if (!o_req) begin
                    m_phase = P_LEAVING;
                end
            end
            P_SETTLE: begin m_wait = 0; m_phase = P_AWAIT; end
            P_AWAIT: begin
                if (buf_in_commit_ack) begin
                    owner_pulse(1'b0); m_phase = P_DRAIN;
                end else begin
                    m_wait++;
                    if (m_wait >= TO) begin owner_pulse(1'b1); m_phase = P_LEAVING; end
                end
            end
            P_DRAIN: if (!buf_in_commit_ack) m_phase = P_LEAVING;
            default: begin
                m_favour_b = (m_owner == 1);
                m_owner = 0; m_phase = P_FREE;
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Compare process and event monitors
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         last_wren_cyc = 0, commit_rise_cyc = 0, a_err_cyc = 0;
    int         commit_cycles = 0, b_gnt_cycles = 0;
    int         a_done_cnt = 0, a_err_cnt = 0, b_done_cnt = 0, b_err_cnt = 0;
    logic       prev_commit = 1'b0;
    logic [1:0] prev_owner = 2'b00;
    logic [1:0] owner_seq[$];

    always @(posedge ext_clk) begin
        logic held, e_a_gnt, e_b_gnt;
        cyc++;
        if (!reset_n) model_reset();
        else          model_step();
        #1;
        if (reset_n) begin
            held    = (m_phase >= P_WRITING) && (m_phase <= P_DRAIN);
            e_a_gnt = held && (m_owner == 1);
            e_b_gnt = held && (m_owner == 2);
            check("a_gnt", a_gnt, e_a_gnt);
            check("b_gnt", b_gnt, e_b_gnt);
            check("stat_owner", stat_owner, {e_b_gnt, e_a_gnt});
            check("buf_in_wren", buf_in_wren, e_wren);
            if (e_wren) begin
                check("buf_in_addr", buf_in_addr, e_addr);
                check("buf_in_data", buf_in_data, e_data);
            end
            check("buf_in_commit", buf_in_commit, (m_phase == P_AWAIT));
            if (m_phase == P_AWAIT) check("buf_in_commit_len", buf_in_commit_len, m_len);
            check("a_done", a_done, e_a_done);
            check("a_err", a_err, e_a_err);
            check("b_done", b_done, e_b_done);
            check("b_err", b_err, e_b_err);

            if (buf_in_wren) last_wren_cyc = cyc;
            if (buf_in_commit && !prev_commit) commit_rise_cyc = cyc;
            if (buf_in_commit) commit_cycles++;
            if (b_gnt) b_gnt_cycles++;
            if (a_done) a_done_cnt++;
            if (b_done) b_done_cnt++;
            if (a_err) begin a_err_cnt++; a_err_cyc = cyc; end
            if (b_err) b_err_cnt++;
            if (stat_owner != 2'b00 && prev_owner == 2'b00) owner_seq.push_back(stat_owner);
        end
        prev_commit = buf_in_commit;
        prev_owner  = stat_owner;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge ext_clk);
    endtask

    task automatic wait_gnt(input bit want_b, input string what);
        int n = 0;
        while (!(want_b ? b_gnt : a_gnt) && n < 60) begin tick(1); n++; end
        if (n >= 60) expire(what);
    endtask

    task automatic wait_any_gnt(input string what);
        int n = 0;
        while (!(a_gnt || b_gnt) && n < 60) begin tick(1); n++; end
        if (n >= 60) expire(what);
    endtask

    task automatic wait_free(input string what);
        int n = 0;
        while ((a_gnt || b_gnt) && n < 300) begin tick(1); n++; end
        if (n >= 300) expire(what);
    endtask

    task automatic wait_commit(input string what);
        int n = 0;
        while (!buf_in_commit && n < 20) begin tick(1); n++; end
        if (n >= 20) expire(what);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base0, base1;
        int         qbase;
        int         seen;
        logic [9:0] lenv;
        reset_n = 1'b0;
        a_req = 0; a_wren = 0; a_commit = 0; a_addr = 0; a_data = 0; a_commit_len = 0;
        b_req = 0; b_wren = 0; b_commit = 0; b_addr = 0; b_data = 0; b_commit_len = 0;
        buf_in_ready = 0; buf_in_commit_ack = 0;
        tick(3);
        check("reset outputs", {a_gnt, b_gnt, a_done, a_err, b_done, b_err, buf_in_wren,
                                buf_in_commit, stat_owner, buf_in_commit_len}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // ---- A alone: 64 writes, commit len 64 with the last write --------
        base0 = a_done_cnt; base1 = b_gnt_cycles;
        buf_in_ready = 1; a_req = 1;
        wait_gnt(1'b0, "t1 grant A");
        for (int i = 0; i < 64; i++) begin
            a_addr = 9'(i + 16); a_data = 8'(i * 7 + 3); a_wren = 1;
            b_addr = 9'(300 + i); b_data = 8'(255 - i); b_wren = 1;
            if (i == 63) begin a_commit = 1; a_commit_len = 10'd64; end
            tick(1);
        end
        b_wren = 0;
        a_wren = 1; a_commit = 1; a_commit_len = 10'd3;   // lands in COMMIT: ignored
        tick(1);
        a_wren = 0; a_commit = 0;
        wait_commit("t1 commit");
        check("t1 commit_len", buf_in_commit_len, 32'd64);
        a_commit = 1; a_commit_len = 10'd7;               // during WAIT_ACK: ignored
        tick(1);
        a_commit = 0;
        tick(4);
        buf_in_commit_ack = 1; tick(3); buf_in_commit_ack = 0;
        tick(2);
        a_req = 0;
        wait_free("t1 release");
        check("t1 commit after last write", commit_rise_cyc - last_wren_cyc, 32'd1);
        check("t1 a_done count", a_done_cnt - base0, 32'd1);
        check("t1 b_gnt cycles", b_gnt_cycles - base1, 32'd0);
        tick(2);

        // ---- Simultaneous requests after reset: A, B, A --------------------
        reset_n = 1'b0; tick(2); reset_n = 1'b1;
        qbase = owner_seq.size();
        a_req = 1; b_req = 1;
        for (int g = 0; g < 3; g++) begin
            wait_any_gnt("t2 grant");
            if (g == 2) begin
                a_req = 0; b_req = 0;
            end else begin
                lenv = (g == 1) ? 10'd512 : 10'd20;
                if (b_gnt) begin b_commit = 1; b_commit_len = lenv; end
                else       begin a_commit = 1; a_commit_len = lenv; end
                tick(1);
                a_commit = 0; b_commit = 0;
                wait_commit("t2 commit");
                if (g == 1) check("t2 commit_len 512", buf_in_commit_len, 32'd512);
                tick(2);
                buf_in_commit_ack = 1; tick(1); buf_in_commit_ack = 0;
            end
            wait_free("t2 release");
        end
        check("t2 grant count", owner_seq.size() - qbase, 32'd3);
        check("t2 owner 1st", owner_seq[qbase],     32'd1);
        check("t2 owner 2nd", owner_seq[qbase + 1], 32'd2);
        check("t2 owner 3rd", owner_seq[qbase + 2], 32'd1);
        tick(2);

        // ---- B commit len 600 rejected; then A wins a tie; A len 0 rejected
        base0 = b_err_cnt; base1 = commit_cycles;
        b_req = 1;
        wait_gnt(1'b1, "t3 grant B");
        b_commit = 1; b_commit_len = 10'd600;
        tick(1);
        b_commit = 0;
        check("t3 b_err pulse", b_err, 32'd1);
        check("t3 b_gnt released", b_gnt, 32'd0);
        a_req = 1;
        tick(2);
        check("t3 tie to A", {b_gnt, a_gnt}, 32'd1);
        check("t3 b_err count", b_err_cnt - base0, 32'd1);
        check("t3 no commit", commit_cycles - base1, 32'd0);
        a_commit = 1; a_commit_len = 10'd0; a_req = 0; b_req = 0;
        tick(1);
        a_commit = 0;
        check("t3 a_err len0", a_err, 32'd1);
        check("t3 a_gnt released", a_gnt, 32'd0);
        tick(2);

        // ---- A commit len 10, no ack: timeout after TO cycles -------------
        base1 = commit_cycles;
        a_req = 1;
        wait_gnt(1'b0, "t4 grant A");
        a_commit = 1; a_commit_len = 10'd10;
        tick(1);
        a_commit = 0;
        wait_commit("t4 commit");
        check("t4 commit_len", buf_in_commit_len, 32'd10);
        seen = 0;
        while (!a_err && seen < 200) begin tick(1); seen++; end
        if (seen >= 200) expire("t4 timeout err");
        check("t4 err delay", a_err_cyc - commit_rise_cyc, 32'd100);
        check("t4 commit cycles", commit_cycles - base1, 32'd100);
        check("t4 commit dropped", buf_in_commit, 32'd0);
        check("t4 a_gnt released", a_gnt, 32'd0);
        a_req = 0;
        tick(3);

        // ---- Not ready for 20 cycles, then ready ---------------------------
        buf_in_ready = 0; a_req = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (a_gnt || b_gnt) seen++;
        end
        check("t5 no grant while not ready", seen, 32'd0);
        buf_in_ready = 1;
        tick(1);
        check("t5 grant one cycle after ready", a_gnt, 32'd1);
        a_req = 0;
        wait_free("t5 release");
        tick(2);

        // ---- Reset during WAIT_ACK -----------------------------------------
        a_req = 1;
        wait_gnt(1'b0, "t6 grant A");
        a_commit = 1; a_commit_len = 10'd5;
        tick(1);
        a_commit = 0;
        wait_commit("t6 commit");
        tick(3);
        @(posedge ext_clk);
        #3 reset_n = 1'b0;
        #1;
        check("t6 async reset outputs", {a_gnt, b_gnt, a_done, a_err, b_done, b_err,
                                         buf_in_wren, buf_in_commit, stat_owner}, 32'd0);
        tick(2);
        reset_n = 1'b1; a_req = 1; b_req = 1;
        tick(2);
        check("t6 tie to A after reset", {b_gnt, a_gnt}, 32'd1);
        a_req = 0; b_req = 0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
